exec_unit: RTL and testbench

Parametrised, handshaked integer execution unit; next generation of the combinational ALU. Keeps the ALU command set and adds iterative multiply and divide (RISC-V M semantics), registered results, and operand width set by parameter. Sits between decode/register-read and writeback. Accepts one operation at a time over a valid/ready handshake and returns a tagged result.

---
 rtl/exec_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_exec_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: handshaked integer execution unit.
//   Single-cycle ALU commands plus iterative multiply/divide (RISC-V M
//   semantics), registered result, opaque tag carried request -> result.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_command[4:0]            operation code (22..31 return 0)
//   in_lhs, in_rhs [XLEN]      operands
//   in_tag [TAG_WIDTH]         returned unchanged with the result
//   out_valid/out_ready        result handshake
//   out_result [XLEN]          result
//   out_tag [TAG_WIDTH]        tag of the request that produced the result
//   dbg_state [1:0]            current FSM state (0 IDLE,1 ITER,2 FIXUP,3 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its payload stable while valid && !ready. in_ready
// depends only on state and out_ready; no output depends on in_valid
// combinationally.
module exec_unit #(
  parameter int XLEN          = 32,
  parameter int TAG_WIDTH     = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_command,
  input  logic [XLEN-1:0]      in_lhs,
  input  logic [XLEN-1:0]      in_rhs,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [1:0]           dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

  localparam logic [4:0] C_ADD  = 5'd0,  C_SUB    = 5'd1,  C_AND  = 5'd2,  C_OR   = 5'd3;
  localparam logic [4:0] C_XOR  = 5'd4,  C_SLL    = 5'd5,  C_SRL  = 5'd6,  C_SRA  = 5'd7;
  localparam logic [4:0] C_EQ   = 5'd8,  C_NE     = 5'd9,  C_LT   = 5'd10, C_LTU  = 5'd11;
  localparam logic [4:0] C_GE   = 5'd12, C_GEU    = 5'd13, C_MUL  = 5'd14, C_MULH = 5'd15;
  localparam logic [4:0] C_MULHSU = 5'd16, C_MULHU = 5'd17, C_DIV = 5'd18, C_DIVU = 5'd19;
  localparam logic [4:0] C_REM  = 5'd20, C_REMU   = 5'd21;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_t;

  state_t r_state, w_next_state;

  logic [XLEN-1:0]      r_result;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [4:0]           r_cmd;
  logic [XLEN-1:0]      r_hi;     // product high half / partial remainder
  logic [XLEN-1:0]      r_lo;     // multiplier bits / dividend-then-quotient
  logic [XLEN-1:0]      r_b;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]      r_lhs;    // original dividend, returned as remainder on /0
  logic                 r_neg_q;  // negate product or quotient
  logic                 r_neg_r;  // negate remainder (dividend was negative)
  logic                 r_div0;
  logic [SHW-1:0]       r_cnt;

  logic                 w_accept;
  logic                 w_is_muldiv;
  logic [SHW-1:0]       w_shamt;
  logic [XLEN-1:0]      w_simple;
  logic                 w_lhs_signed, w_rhs_signed;
  logic                 w_lhs_neg, w_rhs_neg;
  logic [XLEN-1:0]      w_lhs_mag, w_rhs_mag;
  logic                 w_is_div;
  logic [XLEN:0]        w_sum;
  logic                 w_ge;
  logic [XLEN-1:0]      w_trial;
  logic [XLEN-1:0]      w_step_hi, w_step_lo;
  logic [2*XLEN-1:0]    w_prod, w_prod_s;
  logic [XLEN-1:0]      w_fix;

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign dbg_state  = r_state;

  assign w_accept    = in_valid && in_ready;
  assign w_is_muldiv = (ENABLE_MULDIV != 0) && (in_command >= C_MUL) && (in_command <= C_REMU);
  assign w_shamt     = in_rhs[SHW-1:0];

  // Single-cycle result; also covers mul/div codes when they are disabled.
  always_comb begin
    w_simple = '0;
    case (in_command)
      C_ADD: w_simple = in_lhs + in_rhs;
      C_SUB: w_simple = in_lhs - in_rhs;
      C_AND: w_simple = in_lhs & in_rhs;
      C_OR:  w_simple = in_lhs | in_rhs;
      C_XOR: w_simple = in_lhs ^ in_rhs;
      C_SLL: w_simple = in_lhs << w_shamt;
      C_SRL: w_simple = in_lhs >> w_shamt;
      C_SRA: w_simple = $signed(in_lhs) >>> w_shamt;
      C_EQ:  w_simple[0] = (in_lhs == in_rhs);
      C_NE:  w_simple[0] = (in_lhs != in_rhs);
      C_LT:  w_simple[0] = ($signed(in_lhs) < $signed(in_rhs));
      C_LTU: w_simple[0] = (in_lhs < in_rhs);
      C_GE:  w_simple[0] = ($signed(in_lhs) >= $signed(in_rhs));
      C_GEU: w_simple[0] = (in_lhs >= in_rhs);
      default: w_simple = '0;
    endcase
  end

  // Operand signedness by command; MULHSU treats only lhs as signed.
  always_comb begin
    w_lhs_signed = 1'b0;
    w_rhs_signed = 1'b0;
    case (in_command)
      C_MUL, C_MULH, C_DIV, C_REM: begin
        w_lhs_signed = 1'b1;
        w_rhs_signed = 1'b1;
      end
      C_MULHSU: w_lhs_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_lhs_neg = w_lhs_signed && in_lhs[XLEN-1];
  assign w_rhs_neg = w_rhs_signed && in_rhs[XLEN-1];
  // The magnitude of the most negative value is representable as unsigned.
  assign w_lhs_mag = w_lhs_neg ? (-in_lhs) : in_lhs;
  assign w_rhs_mag = w_rhs_neg ? (-in_rhs) : in_rhs;

  // One radix-2 step of either shift-add multiply or restoring divide.
  assign w_is_div = (r_cmd >= C_DIV);
  assign w_sum    = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
  assign w_ge     = ({r_hi, r_lo[XLEN-1]} >= {1'b0, r_b});
  // Only used when w_ge, where the true difference is below r_b and fits XLEN.
  assign w_trial  = {r_hi[XLEN-2:0], r_lo[XLEN-1]} - r_b;

  always_comb begin
    if (w_is_div) begin
      w_step_hi = w_ge ? w_trial : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
      w_step_lo = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_step_hi = w_sum[XLEN:1];
      w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_q ? (-w_prod) : w_prod;

  always_comb begin
    w_fix = '0;
    case (r_cmd)
      C_MUL:                     w_fix = w_prod_s[XLEN-1:0];
      C_MULH, C_MULHSU, C_MULHU: w_fix = w_prod_s[2*XLEN-1:XLEN];
      C_DIV, C_DIVU:             w_fix = r_div0 ? '1 : (r_neg_q ? (-r_lo) : r_lo);
      C_REM, C_REMU:             w_fix = r_div0 ? r_lhs : (r_neg_r ? (-r_hi) : r_hi);
      default:                   w_fix = '0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = w_is_muldiv ? S_ITER : S_DONE;
      S_ITER:  if (r_cnt == LAST_STEP) w_next_state = S_FIXUP;
      S_FIXUP: w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) w_next_state = w_is_muldiv ? S_ITER : S_DONE;
          else          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_tag    <= '0;
      r_cmd    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_lhs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_tag <= in_tag;
      if (w_is_muldiv) begin
        r_cmd   <= in_command;
        r_hi    <= '0;
        r_lo    <= w_lhs_mag;
        r_b     <= w_rhs_mag;
        r_lhs   <= in_lhs;
        r_neg_q <= w_lhs_neg ^ w_rhs_neg;
        r_neg_r <= w_lhs_neg;
        r_div0  <= (in_rhs == '0);
        r_cnt   <= '0;
      end else begin
        r_result <= w_simple;
      end
    end else if (r_state == S_ITER) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt + 1'b1;  // wraps to 0 after the last step
    end else if (r_state == S_FIXUP) begin
      r_result <= w_fix;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 32-bit DUT with mul/div
  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
  logic [4:0]  in_command32 = '0;
  logic [31:0] in_lhs32 = '0, in_rhs32 = '0, out_result32;
  logic [3:0]  in_tag32 = '0, out_tag32;
  logic [1:0]  dbg_state32;

  // 16-bit DUT without mul/div
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1;
  logic [4:0]  in_command16 = '0;
  logic [15:0] in_lhs16 = '0, in_rhs16 = '0, out_result16;
  logic [3:0]  in_tag16 = '0, out_tag16;
  logic [1:0]  dbg_state16;

  logic [31:0] exp_q[$];
  logic [3:0]  exp_tag_q[$];

  exec_unit #(.XLEN(32), .TAG_WIDTH(4), .ENABLE_MULDIV(1)) u_dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_command(in_command32),
    .in_lhs(in_lhs32), .in_rhs(in_rhs32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_result(out_result32), .out_tag(out_tag32), .dbg_state(dbg_state32)
  );

  exec_unit #(.XLEN(16), .TAG_WIDTH(4), .ENABLE_MULDIV(0)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_command(in_command16),
    .in_lhs(in_lhs16), .in_rhs(in_rhs16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_result(out_result16), .out_tag(out_tag16), .dbg_state(dbg_state16)
  );

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1. Latency counts negedges after the accept
  // edge up to and including the first one that sees out_valid.
  task automatic do_op32(input logic [4:0] cmd, input logic [31:0] lhs, input logic [31:0] rhs,
                         input logic [3:0] tag, input logic [31:0] exp_res, input int exp_lat,
                         input string name);
    int lat;
    bit got;
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready32);
    end
    in_command32 = cmd; in_lhs32 = lhs; in_rhs32 = rhs; in_tag32 = tag; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0; in_lhs32 = '1; in_rhs32 = '1; in_tag32 = '1;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid32 === 1'b1) got = 1;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (out_result32 !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, out_result32, exp_res);
    end
    n_checks++;
    if (out_tag32 !== tag) begin
      n_fail++;
      $display("FAIL %s tag: got %h want %h", name, out_tag32, tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op16(input logic [4:0] cmd, input logic [15:0] lhs, input logic [15:0] rhs,
                         input logic [3:0] tag, input logic [15:0] exp_res, input string name);
    int lat;
    bit got;
    in_command16 = cmd; in_lhs16 = lhs; in_rhs16 = rhs; in_tag16 = tag; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid16 === 1'b1) got = 1;
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 1", name, lat);
    end
    n_checks++;
    if (out_result16 !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, out_result16, exp_res);
    end
    n_checks++;
    if (out_tag16 !== tag) begin
      n_fail++;
      $display("FAIL %s tag: got %h want %h", name, out_tag16, tag);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid32); end
    n_checks++;
    if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready32); end
    n_checks++;
    if (out_result32 !== 32'h0) begin n_fail++; $display("FAIL reset out_result: got %h want 0", out_result32); end
    n_checks++;
    if (out_tag32 !== 4'h0) begin n_fail++; $display("FAIL reset out_tag: got %h want 0", out_tag32); end
    n_checks++;
    if (dbg_state32 !== 2'd0) begin n_fail++; $display("FAIL reset state: got %0d want 0", dbg_state32); end
    n_checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset16 handshake: got valid=%b ready=%b want 0/1", out_valid16, in_ready16);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  cmds [4] = '{5'd0, 5'd7, 5'd10, 5'd11};
    logic [31:0] lhss [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] rhss [4] = '{32'h1, 32'h24, 32'h1, 32'h1};
    logic [31:0] exps [4] = '{32'h0, 32'hF800_0000, 32'h1, 32'h0};
    logic [31:0] e;
    logic [3:0]  t;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      exp_tag_q.push_back(4'(i + 1));
    end
    out_ready32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        in_command32 = cmds[i]; in_lhs32 = lhss[i]; in_rhs32 = rhss[i];
        in_tag32 = 4'(i + 1); in_valid32 = 1'b1;
      end else begin
        in_valid32 = 1'b0;
      end
      if (i > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        t = exp_tag_q.pop_front();
        n_checks++;
        if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] out_valid: got %b want 1", i - 1, out_valid32); end
        n_checks++;
        if (out_result32 !== e) begin n_fail++; $display("FAIL b2b[%0d] result: got %h want %h", i - 1, out_result32, e); end
        n_checks++;
        if (out_tag32 !== t) begin n_fail++; $display("FAIL b2b[%0d] tag: got %h want %h", i - 1, out_tag32, t); end
        n_checks++;
        if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] in_ready: got %b want 1", i - 1, in_ready32); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL b2b idle out_valid: got %b want 0", out_valid32); end
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    do_op32(5'd14, 32'd7,         32'hFFFF_FFFD, 4'h6, 32'hFFFF_FFEB, 34, "mul");
    do_op32(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h7, 32'hFFFF_FFFE, 34, "mulhu");
    do_op32(5'd16, 32'hFFFF_FFFF, 32'd2,         4'h8, 32'hFFFF_FFFF, 34, "mulhsu");
    do_op32(5'd15, 32'hFFFF_FFFF, 32'd2,         4'h9, 32'hFFFF_FFFF, 34, "mulh");
  endtask

  task automatic test_divide();
    do_op32(5'd18, 32'hFFFF_FFF9, 32'd2,         4'h1, 32'hFFFF_FFFD, 34, "div_neg");
    do_op32(5'd20, 32'hFFFF_FFF9, 32'd2,         4'h2, 32'hFFFF_FFFF, 34, "rem_neg");
    do_op32(5'd19, 32'd5,         32'd0,         4'h3, 32'hFFFF_FFFF, 34, "divu_zero");
    do_op32(5'd20, 32'd5,         32'd0,         4'h4, 32'd5,         34, "rem_zero");
    do_op32(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 4'h5, 32'h8000_0000, 34, "div_ovf");
    do_op32(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 32'h0,         34, "rem_ovf");
    do_op32(5'd21, 32'd100,       32'd7,         4'h7, 32'd2,         34, "remu");
  endtask

  task automatic test_backpressure();
    int waited;
    out_ready32 = 1'b0;
    in_command32 = 5'd18; in_lhs32 = 32'd100; in_rhs32 = 32'd7; in_tag32 = 4'h9; in_valid32 = 1'b1;
    @(posedge clk); #1;
    // New request held on the inputs the whole time; it must not be taken.
    in_command32 = 5'd0; in_lhs32 = 32'd3; in_rhs32 = 32'd4; in_tag32 = 4'h5;
    waited = 0;
    while (out_valid32 !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited !== 34) begin n_fail++; $display("FAIL bp latency: got %0d want 34", waited); end
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL bp hold valid: got %b want 1", out_valid32); end
      n_checks++;
      if (out_result32 !== 32'd14) begin n_fail++; $display("FAIL bp hold result: got %h want %h", out_result32, 32'd14); end
      n_checks++;
      if (out_tag32 !== 4'h9) begin n_fail++; $display("FAIL bp hold tag: got %h want 9", out_tag32); end
      n_checks++;
      if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL bp hold in_ready: got %b want 0", in_ready32); end
    end
    out_ready32 = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b want 1", in_ready32); end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL bp next valid: got %b want 1", out_valid32); end
    n_checks++;
    if (out_result32 !== 32'd7) begin n_fail++; $display("FAIL bp next result: got %h want 7", out_result32); end
    n_checks++;
    if (out_tag32 !== 4'h5) begin n_fail++; $display("FAIL bp next tag: got %h want 5", out_tag32); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_iter();
    out_ready32 = 1'b1;
    in_command32 = 5'd14; in_lhs32 = 32'd7; in_rhs32 = 32'd3; in_tag32 = 4'hA; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (dbg_state32 !== 2'd1) begin n_fail++; $display("FAIL midreset pre state: got %0d want 1", dbg_state32); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid: got %b want 0", out_valid32); end
    n_checks++;
    if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL midreset in_ready: got %b want 1", in_ready32); end
    n_checks++;
    if (out_result32 !== 32'h0 || out_tag32 !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset regs: got %h/%h want 0/0", out_result32, out_tag32);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL midreset discarded: got %b want 0", out_valid32); end
    @(posedge clk); #1;
    do_op32(5'd1, 32'd10, 32'd3, 4'hB, 32'd7, 1, "post_reset_sub");
  endtask

  task automatic test_params16();
    do_op16(5'd5,  16'h0001, 16'h0013, 4'h1, 16'h0008, "p16_sll");
    do_op16(5'd14, 16'h0007, 16'h0003, 4'h2, 16'h0000, "p16_mul_off");
    do_op16(5'd0,  16'h0005, 16'h0006, 4'h3, 16'h000B, "p16_add");
    do_op16(5'd31, 16'h1234, 16'h5678, 4'h4, 16'h0000, "p16_cmd31");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_back_to_back();
    test_multiply();
    test_divide();
    test_backpressure();
    test_reset_mid_iter();
    test_params16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
